// File: rtl/systolic_array_nxn.sv
// Output-stationary NxN systolic multiplier: C = A x B, operands streamed row-major,
// result rows drained on a valid/ready interface, optional accumulation across runs.
module systolic_array_nxn #(
    parameter int N      = 4,
    parameter int DW     = 4,
    parameter int AW     = 2*DW + $clog2(N),
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DW-1:0]         in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  acc_keep,
    output logic [N*AW-1:0]       out_row,
    output logic [$clog2(N)-1:0]  out_row_idx,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);

    localparam int CW = $clog2(N*N + 3*N);
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {LOAD_A, LOAD_B, COMPUTE, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            keep_q, keep_d;
    logic            accept;

    logic [DW-1:0]   a_q    [N][N];
    logic [DW-1:0]   b_q    [N][N];
    logic [DW-1:0]   a_pe_q [N][N-1];
    logic [DW-1:0]   b_pe_q [N-1][N];
    logic [AW-1:0]   acc_q  [N][N];
    logic [DW-1:0]   a_in   [N][N];
    logic [DW-1:0]   b_in   [N][N];
    logic [DW-1:0]   edge_a [N];
    logic [DW-1:0]   edge_b [N];

    function automatic logic [AW-1:0] mac_term(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic signed [2*DW-1:0] p;
        if (SIGNED != 0) begin
            p = $signed(a) * $signed(b);
            return AW'(p);
        end
        p = $signed({{DW{1'b0}}, a} * {{DW{1'b0}}, b});
        return AW'($unsigned(p));
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= LOAD_A;
            cnt_q   <= '0;
            keep_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            keep_q  <= keep_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        keep_d    = keep_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            LOAD_A: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (cnt_q == '0) keep_d = acc_keep;
                    if (cnt_q == CW'(N*N-1)) begin
                        state_d = LOAD_B;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (cnt_q == CW'(N*N-1)) begin
                        state_d = COMPUTE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            COMPUTE: begin
                if (cnt_q == CW'(3*N-2)) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (cnt_q == CW'(N-1)) begin
                        state_d = LOAD_A;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = LOAD_A;
        endcase
    end

    assign accept      = in_valid && in_ready;
    assign busy        = !(state_q == LOAD_A && cnt_q == '0);
    assign out_last    = (state_q == DRAIN) && (cnt_q == CW'(N-1));
    assign out_row_idx = (state_q == DRAIN) ? cnt_q[IW-1:0] : '0;

    // Skew: edge row i / column j sees operand k on compute cycle i+1+k / j+1+k.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            edge_a[i] = '0;
            edge_b[i] = '0;
            for (int k = 0; k < N; k++) begin
                if (state_q == COMPUTE && cnt_q == CW'(i + 1 + k)) begin
                    edge_a[i] = a_q[i][k];
                    edge_b[i] = b_q[k][i];
                end
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            if (gj == 0) begin : g_a_edge
                assign a_in[gi][gj] = edge_a[gi];
            end else begin : g_a_pass
                assign a_in[gi][gj] = a_pe_q[gi][gj-1];
            end
            if (gi == 0) begin : g_b_edge
                assign b_in[gi][gj] = edge_b[gj];
            end else begin : g_b_pass
                assign b_in[gi][gj] = b_pe_q[gi-1][gj];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_q[i][j]   <= '0;
                    b_q[i][j]   <= '0;
                    acc_q[i][j] <= '0;
                    if (j < N-1) a_pe_q[i][j] <= '0;
                    if (i < N-1) b_pe_q[i][j] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (accept && state_q == LOAD_A && cnt_q == CW'(i*N + j)) a_q[i][j] <= in_data;
                    if (accept && state_q == LOAD_B && cnt_q == CW'(i*N + j)) b_q[i][j] <= in_data;
                    if (state_q == COMPUTE) begin
                        // Cycle 0 flushes the operand pipes and optionally the accumulators.
                        if (cnt_q == '0) begin
                            if (!keep_q) acc_q[i][j] <= '0;
                            if (j < N-1) a_pe_q[i][j] <= '0;
                            if (i < N-1) b_pe_q[i][j] <= '0;
                        end else begin
                            acc_q[i][j] <= acc_q[i][j] + mac_term(a_in[i][j], b_in[i][j]);
                            if (j < N-1) a_pe_q[i][j] <= a_in[i][j];
                            if (i < N-1) b_pe_q[i][j] <= b_in[i][j];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        out_row = '0;
        if (state_q == DRAIN) begin
            for (int r = 0; r < N; r++) begin
                for (int j = 0; j < N; j++) begin
                    if (cnt_q == CW'(r)) out_row[j*AW +: AW] = acc_q[r][j];
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_array_nxn.sv
// Directed bench for systolic_array_nxn: unsigned and signed 4x4 instances share stimulus.
module tb_systolic_array_nxn;

    localparam int N  = 4;
    localparam int DW = 4;
    localparam int AW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [DW-1:0] in_data;
    logic          in_valid, acc_keep, out_ready;

    logic          in_ready_u, out_last_u, out_valid_u, busy_u;
    logic [N*AW-1:0] out_row_u;
    logic [1:0]    out_row_idx_u;
    logic          in_ready_s, out_last_s, out_valid_s, busy_s;
    logic [N*AW-1:0] out_row_s;
    logic [1:0]    out_row_idx_s;

    systolic_array_nxn #(.N(N), .DW(DW), .AW(AW), .SIGNED(0)) dut_u (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_u),
        .acc_keep(acc_keep), .out_row(out_row_u), .out_row_idx(out_row_idx_u), .out_last(out_last_u),
        .out_valid(out_valid_u), .out_ready(out_ready), .busy(busy_u)
    );

    systolic_array_nxn #(.N(N), .DW(DW), .AW(AW), .SIGNED(1)) dut_s (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_s),
        .acc_keep(acc_keep), .out_row(out_row_s), .out_row_idx(out_row_idx_s), .out_last(out_last_s),
        .out_valid(out_valid_s), .out_ready(out_ready), .busy(busy_s)
    );

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] A [16];
    logic [DW-1:0] B [16];
    logic [AW-1:0] expc [16];
    bit gaps = 1'b0;
    bit junk = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [DW-1:0] d);
        if (gaps) begin
            while ($urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                in_data  = DW'($urandom);
                @(posedge clk); #1;
            end
        end
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic load(input logic keep);
        for (int k = 0; k < 16; k++) begin
            acc_keep = (k == 0) ? keep : ~keep;
            send(A[k]);
            if (k == 0) check("busy_loading", 64'(busy_u), 64'(1));
        end
        acc_keep = 1'b0;
        for (int k = 0; k < 16; k++) send(B[k]);
    endtask

    task automatic wait_valid();
        int n = 0;
        if (junk) begin
            in_valid = 1'b1;
            in_data  = 4'hF;
        end
        while (out_valid_u !== 1'b1 && n < 100) begin
            check("in_ready_compute", 64'(in_ready_u), 64'(0));
            @(posedge clk); #1;
            n++;
        end
        check("latency", 64'(n), 64'(11));
    endtask

    task automatic drain(input bit sel, input bit stall);
        logic [N*AW-1:0] exp_row;
        for (int r = 0; r < N; r++) begin
            for (int j = 0; j < N; j++) exp_row[j*AW +: AW] = expc[r*N + j];
            out_ready = 1'b0;
            if (stall) begin
                repeat (5) begin
                    @(posedge clk); #1;
                    check("stall_row", 64'(sel ? out_row_s : out_row_u), 64'(exp_row));
                    check("stall_in_ready", 64'(in_ready_u), 64'(0));
                end
            end
            check("row", 64'(sel ? out_row_s : out_row_u), 64'(exp_row));
            check("row_idx", 64'(sel ? out_row_idx_s : out_row_idx_u), 64'(r));
            check("row_last", 64'(sel ? out_last_s : out_last_u), 64'(r == N-1));
            check("row_valid", 64'(sel ? out_valid_s : out_valid_u), 64'(1));
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
        in_valid = 1'b0;
        check("valid_after_drain", 64'(out_valid_u), 64'(0));
        check("busy_after_drain", 64'(busy_u), 64'(0));
    endtask

    task automatic run(input logic keep, input bit sel, input bit stall);
        load(keep);
        wait_valid();
        drain(sel, stall);
    endtask

    task automatic set_ident_ramp();
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                A[i*N + k]    = (i == k) ? 4'd1 : 4'd0;
                B[i*N + k]    = DW'(4*i + k);
                expc[i*N + k] = AW'(4*i + k);
            end
        end
    endtask

    task automatic set_uniform(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [AW-1:0] e);
        for (int k = 0; k < 16; k++) begin
            A[k] = a;
            B[k] = b;
            expc[k] = e;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_data = '0; acc_keep = 1'b0; out_ready = 1'b0;
        #12;
        check("rst_in_ready", 64'(in_ready_u), 64'(1));
        check("rst_out_valid", 64'(out_valid_u), 64'(0));
        check("rst_out_last", 64'(out_last_u), 64'(0));
        check("rst_out_row", 64'(out_row_u), 64'(0));
        check("rst_row_idx", 64'(out_row_idx_u), 64'(0));
        check("rst_busy", 64'(busy_u), 64'(0));
        check("rst_busy_s", 64'(busy_s), 64'(0));
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        // Identity times ramp returns the ramp.
        set_ident_ramp();
        run(1'b0, 1'b0, 1'b0);

        // Full-scale unsigned, then accumulate to wrap: 1800 mod 1024 = 776.
        set_uniform(4'd15, 4'd15, 10'd900);
        run(1'b0, 1'b0, 1'b0);
        set_uniform(4'd15, 4'd15, 10'd776);
        run(1'b1, 1'b0, 1'b0);

        // Signed: -8*7*4 = -224, -8*-8*4 = 256.
        set_uniform(4'h8, 4'd7, 10'h320);
        run(1'b0, 1'b1, 1'b0);
        set_uniform(4'h8, 4'h8, 10'd256);
        run(1'b0, 1'b1, 1'b0);

        // Clear / keep / clear sequence.
        set_uniform(4'd1, 4'd1, 10'd4);
        run(1'b0, 1'b0, 1'b0);
        set_uniform(4'd1, 4'd1, 10'd8);
        run(1'b1, 1'b0, 1'b0);
        set_uniform(4'd1, 4'd1, 10'd4);
        run(1'b0, 1'b0, 1'b0);

        // Input gaps, output stalls and stray in_valid while busy: C[r][j] = 2*sum_k(4k+j) = 48+8j.
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                A[i*N + k]    = 4'd2;
                B[i*N + k]    = DW'(4*i + k);
                expc[i*N + k] = AW'(48 + 8*k);
            end
        end
        gaps = 1'b1; junk = 1'b1;
        run(1'b0, 1'b0, 1'b1);
        gaps = 1'b0; junk = 1'b0;

        // Abort in compute cycle 3, then a keep=1 run must see cleared accumulators.
        set_uniform(4'd15, 4'd15, 10'd0);
        load(1'b0);
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b0;
        #1;
        check("abort_valid", 64'(out_valid_u), 64'(0));
        check("abort_busy", 64'(busy_u), 64'(0));
        check("abort_in_ready", 64'(in_ready_u), 64'(1));
        repeat (2) begin
            @(posedge clk); #1;
            check("abort_hold_valid", 64'(out_valid_u), 64'(0));
        end
        reset = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("post_abort_valid", 64'(out_valid_u), 64'(0));
        end
        set_ident_ramp();
        run(1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
